// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 clock,
// deserialises 11-bit device-to-host frames, checks start/parity/stop,
// and queues good scan-code bytes in a small FIFO with a valid/ready head.
module ps2_keyb_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_AW     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q, filt_dly_q;
    logic [FW-1:0] fcnt_q;
    logic          fall, dat;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          busy_q, err_q;
    logic          frame_ok, push;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, ovf_q;
    logic          empty, full, pop, push_ok, ovf;

    // 2-FF synchronisers; idle level of both PS/2 lines is high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_dat};
        end
    end

    // Clock deglitch: level flips only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            filt_dly_q <= filt_q;
            if (clk_s_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= ~filt_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    assign fall = filt_dly_q & ~filt_q;
    assign dat  = dat_s_q[1];

    // Frame is good on odd parity over data+parity and a high stop bit
    assign frame_ok = (^{shift_q, par_q}) & dat;
    assign push     = (state_q == S_STOP) & fall & frame_ok;

    // Frame FSM: advances on filtered clock falls, aborts on inter-edge timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == S_IDLE || fall) tmo_q <= '0;
            else                           tmo_q <= tmo_q + TW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE: if (!dat) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                    S_DATA: begin
                        shift_q   <= {dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_q   <= dat;
                        state_q <= S_STOP;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= ~frame_ok;
                    end
                endcase
            end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                tmo_q   <= '0;
            end
        end
    end

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                     (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign pop     = ~empty & ready_i;
    assign push_ok = push & (~full | pop);
    assign ovf     = push & full & ~pop;
    assign rptr_d  = rptr_q + PW'(pop);
    assign wptr_d  = wptr_q + PW'(push_ok);

    // Next head byte; bypass when the new head is the entry being written now
    always_comb begin
        data_d = '0;
        if (rptr_d != wptr_d) begin
            if (push_ok && rptr_d == wptr_q) data_d = shift_q;
            else                             data_d = mem_q[rptr_d[FIFO_AW-1:0]];
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= shift_q;
    end

    // FIFO pointers and registered head/valid/overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            data_q  <= data_d;
            valid_q <= (rptr_d != wptr_d);
            ovf_q   <= ovf;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = err_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = busy_q;
endmodule
